// File: rtl/morse_pkg.sv
// Shared types and default timing constants for the Morse key sequencer.
package morse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPress,
    StGap,
    StEmit,
    StWordWait
  } state_e;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int unsigned DEF_DASH_TICKS       = 3;
  localparam int unsigned DEF_LETTER_GAP_TICKS = 3;
  localparam int unsigned DEF_WORD_GAP_TICKS   = 7;
  localparam int unsigned DEF_CNT_W            = 4;
  localparam int unsigned DEF_MAX_SYMBOLS      = 5;

endpackage

// File: rtl/morse_tick_counter.sv
// Saturating tick counter with synchronous clear and a terminal compare (count >= term).
module morse_tick_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q >= term_i);

endmodule

// File: rtl/morse_key_sequencer.sv
// Times key presses and gaps against a unit tick, shifts dot/dash symbols into an external
// register and reports letter completion, word gaps and symbol overflow.
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned DASH_TICKS       = DEF_DASH_TICKS,
  parameter int unsigned LETTER_GAP_TICKS = DEF_LETTER_GAP_TICKS,
  parameter int unsigned WORD_GAP_TICKS   = DEF_WORD_GAP_TICKS,
  parameter int unsigned CNT_W            = DEF_CNT_W,
  parameter int unsigned MAX_SYMBOLS      = DEF_MAX_SYMBOLS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key,
  output logic       sr_en,
  output logic       sr_si,
  output logic       sr_clr_n,
  output logic       letter_valid,
  output logic [2:0] letter_len,
  output logic       word_space,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] DashTerm   = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] LetterTerm = CNT_W'(LETTER_GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] WordTerm   = CNT_W'(WORD_GAP_TICKS - 1);
  localparam logic [2:0]       MaxSym     = 3'(MAX_SYMBOLS);

  state_e     state_q, state_d;
  logic       key_q, key_d;
  logic [2:0] sym_cnt_q, sym_cnt_d;
  logic       sr_en_q, sr_en_d;
  logic       sr_si_q, sr_si_d;
  logic       sr_clr_n_q, sr_clr_n_d;
  logic       letter_valid_q, letter_valid_d;
  logic [2:0] letter_len_q, letter_len_d;
  logic       word_space_q, word_space_d;
  logic       overflow_q, overflow_d;

  logic             rise, fall;
  logic             press_clr, press_en, press_hit;
  logic             gap_clr, gap_en, gap_hit;
  logic [CNT_W-1:0] gap_term;

  assign rise     = key & ~key_q;
  assign fall     = ~key & key_q;
  assign press_en = tick & (state_q == StPress) & ~fall;
  assign gap_en   = tick & ((state_q == StGap) | (state_q == StWordWait));
  // The gap counter serves both the letter and the word threshold.
  assign gap_term = (state_q == StGap) ? LetterTerm : WordTerm;

  morse_tick_counter #(
    .CNT_W(CNT_W)
  ) u_press_cnt (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (press_clr),
    .en_i   (press_en),
    .term_i (DashTerm),
    .hit_o  (press_hit)
  );

  morse_tick_counter #(
    .CNT_W(CNT_W)
  ) u_gap_cnt (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (gap_clr),
    .en_i   (gap_en),
    .term_i (gap_term),
    .hit_o  (gap_hit)
  );

  always_comb begin
    state_d        = state_q;
    sym_cnt_d      = sym_cnt_q;
    sr_en_d        = 1'b0;
    sr_si_d        = 1'b0;
    sr_clr_n_d     = 1'b1;
    letter_valid_d = 1'b0;
    letter_len_d   = 3'd0;
    word_space_d   = 1'b0;
    overflow_d     = 1'b0;
    press_clr      = 1'b0;
    gap_clr        = 1'b0;
    // Freeze the key history during EMIT so a rise there is still seen in WORDWAIT.
    key_d          = (state_q == StEmit) ? key_q : key;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          press_clr = 1'b1;
          state_d   = StPress;
        end
      end
      StPress: begin
        if (fall) begin
          if (sym_cnt_q < MaxSym) begin
            sr_en_d   = 1'b1;
            sr_si_d   = press_hit ? SYM_DASH : SYM_DOT;
            sym_cnt_d = sym_cnt_q + 3'd1;
            gap_clr   = 1'b1;
            state_d   = StGap;
          end else begin
            overflow_d = 1'b1;
            sr_clr_n_d = 1'b0;
            sym_cnt_d  = 3'd0;
            state_d    = StIdle;
          end
        end
      end
      StGap: begin
        if (rise) begin
          press_clr = 1'b1;
          gap_clr   = 1'b1;
          state_d   = StPress;
        end else if (tick && gap_hit) begin
          letter_valid_d = 1'b1;
          letter_len_d   = sym_cnt_q;
          state_d        = StEmit;
        end
      end
      StEmit: begin
        sr_clr_n_d = 1'b0;
        sym_cnt_d  = 3'd0;
        state_d    = StWordWait;
      end
      StWordWait: begin
        if (rise) begin
          press_clr = 1'b1;
          gap_clr   = 1'b1;
          state_d   = StPress;
        end else if (tick && gap_hit) begin
          word_space_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      key_q          <= 1'b0;
      sym_cnt_q      <= 3'd0;
      sr_en_q        <= 1'b0;
      sr_si_q        <= 1'b0;
      sr_clr_n_q     <= 1'b0;
      letter_valid_q <= 1'b0;
      letter_len_q   <= 3'd0;
      word_space_q   <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      sym_cnt_q      <= sym_cnt_d;
      sr_en_q        <= sr_en_d;
      sr_si_q        <= sr_si_d;
      sr_clr_n_q     <= sr_clr_n_d;
      letter_valid_q <= letter_valid_d;
      letter_len_q   <= letter_len_d;
      word_space_q   <= word_space_d;
      overflow_q     <= overflow_d;
    end
  end

  assign sr_en        = sr_en_q;
  assign sr_si        = sr_si_q;
  assign sr_clr_n     = sr_clr_n_q;
  assign letter_valid = letter_valid_q;
  assign letter_len   = letter_len_q;
  assign word_space   = word_space_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Randomised and directed bench for morse_key_sequencer with a queue-based reference model.
module tb_morse_key_sequencer;

  localparam int DT = 3;
  localparam int LG = 3;
  localparam int WG = 7;
  localparam int MS = 5;

  localparam int MIdle = 0, MPress = 1, MGap = 2, MEmit = 3, MWord = 4;

  logic       clk = 1'b0;
  logic       reset, tick, key;
  logic       sr_en, sr_si, sr_clr_n, letter_valid, word_space, overflow;
  logic [2:0] letter_len;

  always #5 clk = ~clk;

  morse_key_sequencer #(
    .DASH_TICKS      (DT),
    .LETTER_GAP_TICKS(LG),
    .WORD_GAP_TICKS  (WG),
    .CNT_W           (4),
    .MAX_SYMBOLS     (MS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .key         (key),
    .sr_en       (sr_en),
    .sr_si       (sr_si),
    .sr_clr_n    (sr_clr_n),
    .letter_valid(letter_valid),
    .letter_len  (letter_len),
    .word_space  (word_space),
    .overflow    (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: symbols of the current letter, tick counts of the current press/gap.
  bit   model_on = 1'b0;
  int   m_mode = MIdle;
  int   m_press = 0, m_gap = 0;
  bit   m_kq = 1'b0;
  bit   syms[$];
  bit   e_en, e_si, e_clr_n, e_lv, e_ws, e_ov;
  int   e_len;
  logic [4:0] e_val;
  logic [4:0] m_last_val = '0;
  int   m_last_len = 0;

  // Downstream shift register fed by the DUT, plus observed event counters.
  logic [4:0] sreg = '0;
  int   dut_lv_n = 0, dut_ws_n = 0, dut_ov_n = 0;
  int   last_len = 0;
  logic [4:0] last_val = '0;

  initial begin : scoreboard
    bit r, k, t, rise, fall, hold;
    int v;
    forever begin
      @(posedge clk);
      r = reset; k = key; t = tick;
      e_en = 0; e_si = 0; e_clr_n = 1; e_lv = 0; e_len = 0; e_ws = 0; e_ov = 0;
      if (r) begin
        model_on = 1'b1;
        e_clr_n  = 0;
        m_mode   = MIdle;
        syms.delete();
        m_kq = 0; m_press = 0; m_gap = 0;
      end else if (model_on) begin
        rise = k && !m_kq;
        fall = !k && m_kq;
        hold = (m_mode == MEmit);
        case (m_mode)
          MIdle: if (rise) begin m_mode = MPress; m_press = 0; end
          MPress: begin
            if (fall) begin
              if (syms.size() < MS) begin
                e_en = 1;
                e_si = (m_press >= DT);
                syms.push_back(e_si);
                m_gap  = 0;
                m_mode = MGap;
              end else begin
                e_ov = 1; e_clr_n = 0;
                syms.delete();
                m_mode = MIdle;
              end
            end else if (t) m_press++;
          end
          MGap: begin
            if (rise) begin
              m_mode = MPress; m_press = 0; m_gap = 0;
            end else if (t) begin
              m_gap++;
              if (m_gap == LG) begin
                e_lv = 1;
                e_len = syms.size();
                v = 0;
                foreach (syms[i]) v = v * 2 + int'(syms[i]);
                e_val = v[4:0];
                m_last_val = e_val;
                m_last_len = e_len;
                m_mode = MEmit;
              end
            end
          end
          MEmit: begin
            e_clr_n = 0;
            syms.delete();
            m_mode = MWord;
          end
          default: begin
            if (rise) begin
              m_mode = MPress; m_press = 0; m_gap = 0;
            end else if (t) begin
              m_gap++;
              if (m_gap == WG) begin e_ws = 1; m_mode = MIdle; end
            end
          end
        endcase
        if (!hold) m_kq = k;
      end
      #1;
      if (model_on) begin
        chk("sr_en", 32'(sr_en), 32'(e_en));
        chk("sr_si", 32'(sr_si), 32'(e_si));
        chk("sr_clr_n", 32'(sr_clr_n), 32'(e_clr_n));
        chk("letter_valid", 32'(letter_valid), 32'(e_lv));
        chk("letter_len", 32'(letter_len), 32'(e_len));
        chk("word_space", 32'(word_space), 32'(e_ws));
        chk("overflow", 32'(overflow), 32'(e_ov));
        if (e_lv) chk("letter_reg", 32'(sreg), 32'(e_val));
        if (letter_valid === 1'b1) begin
          dut_lv_n++;
          last_len = int'(letter_len);
          last_val = sreg;
        end
        if (word_space === 1'b1) dut_ws_n++;
        if (overflow === 1'b1) dut_ov_n++;
        if (sr_clr_n === 1'b0) sreg = '0;
        else if (sr_en === 1'b1) sreg = {sreg[3:0], sr_si};
      end
    end
  end

  bit rand_units = 1'b0;

  task automatic cyc(input bit k, input bit t);
    @(negedge clk);
    key  = k;
    tick = t;
  endtask

  task automatic unit(input bit k);
    int z;
    z = rand_units ? int'($urandom_range(0, 2)) : 1;
    repeat (z) cyc(k, 1'b0);
    cyc(k, 1'b1);
  endtask

  task automatic press(input int n);
    cyc(1'b1, 1'b0);
    repeat (n) unit(1'b1);
  endtask

  task automatic gap(input int m);
    cyc(1'b0, 1'b0);
    repeat (m) unit(1'b0);
  endtask

  task automatic settle();
    repeat (3) cyc(key, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int lv0, ws0, ov0;

  task automatic mark();
    lv0 = dut_lv_n; ws0 = dut_ws_n; ov0 = dut_ov_n;
  endtask

  initial begin : stimulus
    reset = 1'b1; key = 1'b0; tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single dot, then a full word gap.
    mark();
    press(1); gap(7); settle();
    chk("t1_lv_count", 32'(dut_lv_n - lv0), 32'd1);
    chk("t1_len", 32'(last_len), 32'd1);
    chk("t1_val", 32'(last_val), 32'h00);
    chk("t1_ws_count", 32'(dut_ws_n - ws0), 32'd1);
    chk("t1_model_len", 32'(m_last_len), 32'd1);

    // Letter A: dot dash.
    mark();
    press(1); gap(1); press(3); gap(7); settle();
    chk("tA_len", 32'(last_len), 32'd2);
    chk("tA_val", 32'(last_val), 32'h01);
    chk("tA_model_val", 32'(m_last_val), 32'h01);
    chk("tA_ws_count", 32'(dut_ws_n - ws0), 32'd1);

    // Dash threshold: 2 ticks dot, 3 ticks dash, 2 ticks dot.
    press(DT - 1); gap(1); press(DT); gap(1); press(DT - 1); gap(7); settle();
    chk("tB_len", 32'(last_len), 32'd3);
    chk("tB_val", 32'(last_val), 32'h02);
    chk("tB_model_val", 32'(m_last_val), 32'h02);

    // Six dots: the sixth overflows and no letter is reported.
    mark();
    repeat (6) begin press(1); gap(1); end
    gap(7); settle();
    chk("tO_ov_count", 32'(dut_ov_n - ov0), 32'd1);
    chk("tO_lv_count", 32'(dut_lv_n - lv0), 32'd0);
    chk("tO_ws_count", 32'(dut_ws_n - ws0), 32'd0);

    // Rise before gap tick 5 suppresses the word space.
    mark();
    press(1); gap(4); press(1); gap(7); settle();
    chk("tW_lv_count", 32'(dut_lv_n - lv0), 32'd2);
    chk("tW_ws_count", 32'(dut_ws_n - ws0), 32'd1);

    // Reset mid-press after two shifts; the following letter starts fresh.
    mark();
    press(1); gap(1); press(1); gap(1);
    cyc(1'b1, 1'b0); unit(1'b1);
    reset_pulse();
    repeat (DT) unit(1'b1);
    gap(7); settle();
    chk("tR_lv_count", 32'(dut_lv_n - lv0), 32'd1);
    chk("tR_len", 32'(last_len), 32'd1);
    chk("tR_val", 32'(last_val), 32'h01);

    // Randomised presses, gaps, tick spacing and occasional resets.
    rand_units = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 19) == 0) reset_pulse();
      press(int'($urandom_range(0, 5)));
      gap(int'($urandom_range(0, 8)));
    end
    gap(8);
    repeat (10) cyc(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
